mpb_responder: RTL
==================

MPB_RESPONDER -- requirements
Module: mpb_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits; the address is a word index.
REQ-003 Parameter NUM_REGS, default 16, number of implemented registers (power of two, 2..256).
REQ-004 Parameter WAIT_CYCLES, default 1, wait states inserted before rdy (0..15).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 vld  input  1  initiator request valid.
REQ-008 r_w  input  1  1=write, 0=read.
REQ-009 addr  input  ADDR_WIDTH  register word index.
REQ-010 wdata  input  DATA_WIDTH  write data.
REQ-011 rdy  output  1  transfer acknowledge; registered.
REQ-012 rdata  output  DATA_WIDTH  read data, valid only while rdy=1; registered.
REQ-013 err  output  1  error response qualifier, valid only while rdy=1; registered.

Function
REQ-014 FSM states IDLE, WAIT, ACK; rdy=1 only in ACK, for exactly one cycle per transfer.
REQ-015 IDLE: on vld=1, capture r_w/addr/wdata; go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else directly to ACK.
REQ-016 WAIT: decrement counter each cycle; go to ACK in the cycle after counter reaches 0.
REQ-017 Latency: rdy asserts exactly WAIT_CYCLES+1 cycles after the edge on which vld is first sampled in IDLE.
REQ-018 ACK: always return to IDLE next cycle; transfer completes on the edge where vld=1 and rdy=1.
REQ-019 Write: register[captured addr] updated with captured wdata on the edge leaving ACK; rdata=0 during a write ACK.
REQ-020 Read: rdata presents register[captured addr] as of the ACK cycle; a write and read to one register never overlap (one transfer at a time).
REQ-021 Captured values are used even if the initiator changes addr/wdata or drops vld before rdy (protocol violation); the transfer still completes.
REQ-022 Back-to-back: vld held high through ACK starts a new transfer in the following IDLE cycle; minimum transfer period WAIT_CYCLES+2 cycles.
REQ-023 Address in range iff addr < NUM_REGS; upper address bits compared in full, no aliasing.

Reset
REQ-024 While reset_n=0: state IDLE, counter 0, rdy=0, rdata=0, err=0, all registers 0.
REQ-025 Reset asserted mid-transfer aborts it: no register write, no rdy; first transfer after release sampled from IDLE.

Configuration
REQ-026 Macro MPB_RESPONDER_ERR_EN defined: out-of-range access completes with rdy=1, err=1, rdata=0, no register write.
REQ-027 Macro undefined: err tied 0; out-of-range reads return rdata=0, out-of-range writes silently dropped; timing identical.

Structure
REQ-028 Package mpb_responder_pkg holds the FSM state enum, the default parameter constants and the counter width constant (4 bits).
REQ-029 Sub-module mpb_responder_regfile holds the register array: one write port, one combinational read port, async active-low clear.

Verification
REQ-030 WAIT_CYCLES=1, write addr=3 wdata=0xDEADBEEF -> rdy on 2nd cycle after vld, err=0; read addr=3 -> rdata=0xDEADBEEF.
REQ-031 WAIT_CYCLES=0, vld held high with 4 consecutive reads of addr 0..3 after writes 0x11..0x44 -> rdy every 2nd cycle, rdata 0x11,0x22,0x33,0x44.
REQ-032 Read addr=16 with NUM_REGS=16 -> with MPB_RESPONDER_ERR_EN rdy=1 err=1 rdata=0; without it rdy=1 err=0 rdata=0.
REQ-033 WAIT_CYCLES=3, write addr=5, reset_n pulsed low in WAIT -> no rdy, subsequent read addr=5 returns 0.
REQ-034 Write addr=2 wdata=0xA5, initiator changes wdata to 0x5A and drops vld during WAIT -> rdy still asserts, read addr=2 returns 0xA5.
REQ-035 Write addr=0x100000001 style high-bit address (ADDR_WIDTH=32, addr=0x80000001) -> treated out of range, register 1 unchanged.

Source files
------------

// File: rtl/mpb_responder_pkg.sv
// ============================================================================
// Module   : mpb_responder_pkg
// Brief    : Shared types and default constants for the MPB responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpb_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int c_def_data_width  = 32;
    localparam int c_def_addr_width  = 32;
    localparam int c_def_num_regs    = 16;
    localparam int c_def_wait_cycles = 1;
    localparam int c_cnt_width       = 4;

endpackage

`default_nettype wire

// File: rtl/mpb_responder_regfile.sv
// ============================================================================
// Module   : mpb_responder_regfile
// Brief    : Register array, one write port, one combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpb_responder_regfile
    import mpb_responder_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int NUM_REGS   = c_def_num_regs,
    parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_we,
    input  logic [IDX_WIDTH-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_WIDTH-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] w_words [NUM_REGS];

    // Each word owns its flop so no array element has more than one driver.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_q <= '0;
            end else if (i_we && (i_waddr == IDX_WIDTH'(gi))) begin
                r_q <= i_wdata;
            end
        end

        assign w_words[gi] = r_q;
    end

    assign o_rdata = w_words[i_raddr];

endmodule

`default_nettype wire

// File: rtl/mpb_responder.sv
// ============================================================================
// Module   : mpb_responder
// Brief    : MPB register-file responder with programmable wait states.
//            Define MPB_RESPONDER_ERR_EN to flag out-of-range accesses on err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpb_responder
    import mpb_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = c_def_data_width,
    parameter int ADDR_WIDTH  = c_def_addr_width,
    parameter int NUM_REGS    = c_def_num_regs,
    parameter int WAIT_CYCLES = c_def_wait_cycles
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vld,
    input  logic                  r_w,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdy,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err
);

    localparam int c_idx_width = $clog2(NUM_REGS);
    localparam logic [c_cnt_width-1:0] c_wait_load =
        (WAIT_CYCLES > 0) ? c_cnt_width'(WAIT_CYCLES - 1) : '0;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_width-1:0]  r_cnt;
    logic [c_cnt_width-1:0]  w_cnt_nxt;

    logic                    r_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    r_rdy;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_idle;
    logic                    w_capture;
    logic                    w_cur_wr;
    logic [ADDR_WIDTH-1:0]   w_cur_addr;
    logic                    w_in_range;
    logic                    w_enter_ack;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_capture = w_idle && vld;

    // With zero wait states ACK is entered on the capture edge, so the live
    // request must be used before the capture registers hold it.
    assign w_cur_wr    = w_idle ? r_w  : r_wr;
    assign w_cur_addr  = w_idle ? addr : r_addr;
    assign w_in_range  = ((w_cur_addr >> c_idx_width) == '0);
    assign w_enter_ack = (w_state_nxt == ST_ACK);
    assign w_we        = (r_state == ST_ACK) && r_wr && w_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (vld) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_wait_load;
                    end else begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_wr    <= r_w;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdy   <= w_enter_ack;
            r_rdata <= (w_enter_ack && !w_cur_wr && w_in_range) ? w_rd_word : '0;
        end
    end

`ifdef MPB_RESPONDER_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_ack && !w_in_range;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign rdy   = r_rdy;
    assign rdata = r_rdata;

    mpb_responder_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (c_idx_width)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we),
        .i_waddr (r_addr[c_idx_width-1:0]),
        .i_wdata (r_wdata),
        .i_raddr (w_cur_addr[c_idx_width-1:0]),
        .o_rdata (w_rd_word)
    );

endmodule

`default_nettype wire
